// File: rtl/hd44780_byte_sender.sv
// hd44780_byte_sender: sends one byte to an HD44780 LCD over a 4-bit bus (HI then LO nybble) and then waits out the settle delay.
// Optional feature: define H4_BYTE_SENDER_SINGLE_NYBBLE_EN to honour i_single (send the HI nybble only).
module hd44780_byte_sender #(
  parameter int TICKS_TAS   = 3,
  parameter int TICKS_PWEH  = 22,
  parameter int TICKS_TCYCE = 48,
  parameter int DELAY_CMD   = 2544,
  parameter int DELAY_LONG  = 78720,
  parameter int TIMER_BITS  = 17
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       STB_I,
  input  logic [7:0] i_byte,
  input  logic       i_rs,
  input  logic       i_long,
  input  logic       i_single,
  output logic       busy,
  output logic [3:0] o_lcd_nybble,
  output logic       o_rs,
  output logic       o_e
);
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, SETTLE} state_t;
  localparam logic [TIMER_BITS-1:0] L_TAS  = TIMER_BITS'(TICKS_TAS - 1);
  localparam logic [TIMER_BITS-1:0] L_PWEH = TIMER_BITS'(TICKS_PWEH - 1);
  localparam logic [TIMER_BITS-1:0] L_HOLD = TIMER_BITS'(TICKS_TCYCE - TICKS_TAS - TICKS_PWEH - 1);
  localparam logic [TIMER_BITS-1:0] L_CMD  = TIMER_BITS'(DELAY_CMD - 1);
  localparam logic [TIMER_BITS-1:0] L_LONG = TIMER_BITS'(DELAY_LONG - 1);
  state_t                r_state;
  logic                  r_hi;
  logic [3:0]            r_lo;
  logic                  r_long;
  logic [TIMER_BITS-1:0] r_cnt;
  logic                  w_zero;
  logic                  w_last;
  assign w_zero = (r_cnt == '0);
`ifdef H4_BYTE_SENDER_SINGLE_NYBBLE_EN
  logic r_single;
  assign w_last = !r_hi || r_single;
`else
  logic w_unused_single;
  assign w_unused_single = i_single;
  assign w_last = !r_hi;
`endif
  // Nybble sequencer: each state reloads the down-counter on entry and leaves when it reaches zero; outputs are registered with the state.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state      <= IDLE;
      r_hi         <= 1'b1;
      r_lo         <= '0;
      r_long       <= 1'b0;
      r_cnt        <= '0;
      busy         <= 1'b0;
      o_lcd_nybble <= '0;
      o_rs         <= 1'b0;
      o_e          <= 1'b0;
`ifdef H4_BYTE_SENDER_SINGLE_NYBBLE_EN
      r_single     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (STB_I) begin
          r_state      <= SETUP;
          r_hi         <= 1'b1;
          r_lo         <= i_byte[3:0];
          r_long       <= i_long;
          r_cnt        <= L_TAS;
          busy         <= 1'b1;
          o_lcd_nybble <= i_byte[7:4];
          o_rs         <= i_rs;
          o_e          <= 1'b0;
`ifdef H4_BYTE_SENDER_SINGLE_NYBBLE_EN
          r_single     <= i_single;
`endif
        end
        SETUP: if (w_zero) begin
          r_state <= PULSE;
          r_cnt   <= L_PWEH;
          o_e     <= 1'b1;
        end else r_cnt <= r_cnt - TIMER_BITS'(1);
        PULSE: if (w_zero) begin
          r_state <= HOLD;
          r_cnt   <= L_HOLD;
          o_e     <= 1'b0;
        end else r_cnt <= r_cnt - TIMER_BITS'(1);
        HOLD: if (w_zero) begin
          r_state      <= w_last ? SETTLE : SETUP;
          r_cnt        <= w_last ? (r_long ? L_LONG : L_CMD) : L_TAS;
          r_hi         <= 1'b0;
          o_lcd_nybble <= w_last ? o_lcd_nybble : r_lo;
        end else r_cnt <= r_cnt - TIMER_BITS'(1);
        SETTLE: if (w_zero) begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end else r_cnt <= r_cnt - TIMER_BITS'(1);
        default: r_state <= IDLE;
      endcase
    end
  end
  // Parameter sanity: HOLD needs at least one cycle and the counter must fit the longest delay.
  a_tcyce: assert property (@(posedge CLK_I) TICKS_TCYCE >= TICKS_TAS + TICKS_PWEH + 1);
  a_width: assert property (@(posedge CLK_I) DELAY_LONG <= (2 ** TIMER_BITS) && DELAY_CMD <= (2 ** TIMER_BITS));
endmodule

// File: tb/tb_hd44780_byte_sender.sv
// tb_hd44780_byte_sender: self-checking bench with a timeline model of the LCD write waveform plus directed literal checks.
module tb_hd44780_byte_sender;
  localparam int TAS = 3, PWEH = 22, TC = 48, DC = 200, DL = 900;
  logic       CLK_I = 0, RST_I = 1, STB_I = 0, i_rs = 0, i_long = 0, i_single = 0;
  logic [7:0] i_byte = 0;
  logic       busy, o_rs, o_e;
  logic [3:0] o_lcd_nybble;
  int checks = 0, errors = 0, cyc = 0;
  bit active = 0;
  int start = 0, total = 0, nsl = 2;
  logic [7:0] m_byte = 0;
  logic m_rs = 0;
  int rises[$], nybs[$], widths[$], blens[$];
  int es = 0, bs = 0;
  logic pe = 0, pb = 0;

  always #5 CLK_I = ~CLK_I;

  hd44780_byte_sender #(.TICKS_TAS(TAS), .TICKS_PWEH(PWEH), .TICKS_TCYCE(TC),
    .DELAY_CMD(DC), .DELAY_LONG(DL), .TIMER_BITS(17)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .STB_I(STB_I), .i_byte(i_byte), .i_rs(i_rs),
    .i_long(i_long), .i_single(i_single), .busy(busy), .o_lcd_nybble(o_lcd_nybble),
    .o_rs(o_rs), .o_e(o_e));

  function automatic bit mbusy();
    return active && (cyc - start) < total;
  endfunction

  function automatic int at(input int q[$], input int i);
    return i < q.size() ? q[i] : -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a transfer is a timeline starting the cycle after an accepted strobe.
  always @(posedge CLK_I) begin
    if (RST_I) active = 0;
    else if (STB_I && !mbusy()) begin
      active = 1;
      start = cyc + 1;
      m_byte = i_byte;
      m_rs = i_rs;
`ifdef H4_BYTE_SENDER_SINGLE_NYBBLE_EN
      nsl = i_single ? 1 : 2;
`else
      nsl = 2;
`endif
      total = nsl * TC + (i_long ? DL : DC);
    end
    cyc++;
  end

  // Compare every cycle against the model, and record pulse/busy events for directed checks.
  always @(negedge CLK_I) begin
    int k, r;
    if (RST_I) begin
      chk("rst_busy", busy, 0);
      chk("rst_e", o_e, 0);
      chk("rst_rs", o_rs, 0);
      chk("rst_nyb", o_lcd_nybble, 0);
    end else if (mbusy()) begin
      k = cyc - start;
      r = k % TC;
      chk("busy", busy, 1);
      if (k / TC < nsl) begin
        chk("e", o_e, (r >= TAS && r < TAS + PWEH) ? 1 : 0);
        chk("nyb", o_lcd_nybble, (k / TC == 0) ? m_byte[7:4] : m_byte[3:0]);
        chk("rs", o_rs, m_rs);
      end else chk("e_settle", o_e, 0);
    end else begin
      chk("idle_busy", busy, 0);
      chk("idle_e", o_e, 0);
    end
    if (o_e && !pe) begin rises.push_back(cyc); nybs.push_back(o_lcd_nybble); es = cyc; end
    if (!o_e && pe) widths.push_back(cyc - es);
    if (busy && !pb) bs = cyc;
    if (!busy && pb) blens.push_back(cyc - bs);
    pe = o_e;
    pb = busy;
  end

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic clearq();
    rises.delete(); nybs.delete(); widths.delete(); blens.delete();
  endtask

  task automatic send(input logic [7:0] b, input logic rs, input logic lng, input logic sgl);
    i_byte = b; i_rs = rs; i_long = lng; i_single = sgl; STB_I = 1;
    tick();
    STB_I = 0; i_byte = 8'($urandom); i_rs = 1'($urandom); i_long = 1'($urandom); i_single = 1'($urandom);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin tick(); n++; end
    if (busy) begin
      checks++; errors++;
      $display("FAIL wait_idle: busy still %0d after %0d cycles", busy, bound);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) tick();
    RST_I = 0;
    // 0x48 data byte
    clearq(); send(8'h48, 1, 0, 0); wait_idle(5000); tick();
    chk("t1_rises", rises.size(), 2);
    chk("t1_nyb0", at(nybs, 0), 4);
    chk("t1_nyb1", at(nybs, 1), 8);
    chk("t1_gap", at(rises, 1) - at(rises, 0), 48);
    chk("t1_w0", at(widths, 0), 22);
    chk("t1_w1", at(widths, 1), 22);
    chk("t1_busy", at(blens, 0), 2 * 48 + DC);
    // 0x01 clear command, long delay
    clearq(); send(8'h01, 0, 1, 0); wait_idle(5000); tick();
    chk("t2_nyb0", at(nybs, 0), 0);
    chk("t2_nyb1", at(nybs, 1), 1);
    chk("t2_busy", at(blens, 0), 2 * 48 + DL);
    // strobe while busy is ignored
    clearq(); send(8'h48, 1, 0, 0); repeat (9) tick(); send(8'hFF, 0, 0, 0); wait_idle(5000); tick();
    chk("t3_rises", rises.size(), 2);
    chk("t3_nyb0", at(nybs, 0), 4);
    chk("t3_nyb1", at(nybs, 1), 8);
    // back-to-back in the first idle cycle
    clearq(); send(8'h48, 1, 0, 0); wait_idle(5000); send(8'hA5, 0, 0, 0); wait_idle(5000); tick();
    chk("t4_rises", rises.size(), 4);
    chk("t4_nyb2", at(nybs, 2), 10);
    chk("t4_nyb3", at(nybs, 3), 5);
    chk("t4_gap", at(rises, 2) - at(rises, 1), 49 + DC);
    chk("t4_busy1", at(blens, 1), 2 * 48 + DC);
    // reset during E high
    clearq(); send(8'h5A, 1, 0, 0);
    n = 0;
    while (!o_e && n < 100) begin tick(); n++; end
    chk("t5_e_seen", o_e, 1);
    tick(); tick();
    RST_I = 1;
    #1;
    chk("t5_e_drop", o_e, 0);
    chk("t5_busy_drop", busy, 0);
    tick(); tick();
    RST_I = 0;
    clearq(); send(8'hC3, 0, 0, 0); wait_idle(5000); tick();
    chk("t5_nyb0", at(nybs, 0), 12);
    chk("t5_nyb1", at(nybs, 1), 3);
    chk("t5_busy", at(blens, 0), 2 * 48 + DC);
    // single-nybble request
    clearq(); send(8'h30, 0, 0, 1); wait_idle(5000); tick();
    chk("t6_nyb0", at(nybs, 0), 3);
`ifdef H4_BYTE_SENDER_SINGLE_NYBBLE_EN
    chk("t6_rises", rises.size(), 1);
    chk("t6_busy", at(blens, 0), 48 + DC);
`else
    chk("t6_rises", rises.size(), 2);
    chk("t6_busy", at(blens, 0), 2 * 48 + DC);
`endif
    // random traffic with occasional resets
    for (int i = 0; i < 6000; i++) begin
      RST_I = ($urandom_range(0, 999) == 0);
      STB_I = ($urandom_range(0, 5) == 0);
      i_byte = 8'($urandom); i_rs = 1'($urandom); i_long = 1'($urandom); i_single = 1'($urandom);
      tick();
    end
    RST_I = 0; STB_I = 0;
    wait_idle(5000); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
